// File: rtl/mpi_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : mpi_slave_if
// Summary  : Pin-level MPI/Q-bus signal bundle between an initiator and the
//            mpi_slave responder (split AD in/out/oe, active-low strobes).
// Revision : 1.0
// ============================================================================
interface mpi_slave_if;
    logic        pin_init_n;
    logic [15:0] pin_ad_in;
    logic [15:0] pin_ad_out;
    logic        pin_ad_oe;
    logic        pin_sync_n;
    logic        pin_din_n;
    logic        pin_dout_n;
    logic        pin_wtbt_n;
    logic        pin_rply_n;
    logic        irq_req;
    logic        pin_virq_n;
    logic        pin_iako_n;

    modport slave (
        input  pin_init_n,
        input  pin_ad_in,
        input  pin_sync_n,
        input  pin_din_n,
        input  pin_dout_n,
        input  pin_wtbt_n,
        input  irq_req,
        input  pin_iako_n,
        output pin_ad_out,
        output pin_ad_oe,
        output pin_rply_n,
        output pin_virq_n
    );

    modport master (
        output pin_init_n,
        output pin_ad_in,
        output pin_sync_n,
        output pin_din_n,
        output pin_dout_n,
        output pin_wtbt_n,
        output irq_req,
        output pin_iako_n,
        input  pin_ad_out,
        input  pin_ad_oe,
        input  pin_rply_n,
        input  pin_virq_n
    );
endinterface
`default_nettype wire

// File: rtl/mpi_slave.sv
`default_nettype none
// ============================================================================
// Module   : mpi_slave
// Summary  : MPI/Q-bus responder serving word/byte reads and writes from an
//            internal RAM window. Define MPI_VEC_EN for the vectored interrupt.
// Revision : 1.0
// ============================================================================
module mpi_slave #(
    parameter logic [15:0] BASE = 16'o160000,
    parameter int          AW   = 8,
    parameter int          WAIT = 0,
    parameter logic [15:0] VEC  = 16'o000300
) (
    input  logic       clk,
    input  logic       rst_n,
    mpi_slave_if.slave bus
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_RD_WAIT = 3'd2,
        S_RD_RPLY = 3'd3,
        S_WR_WAIT = 3'd4,
        S_WR_RPLY = 3'd5,
        S_END     = 3'd6
`ifdef MPI_VEC_EN
        ,S_IAK    = 3'd7
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_ff_q, din_ff_q, dout_ff_q, wtbt_ff_q;
    logic [15:0]   ad1_q, ad2_q;
    logic          sync_prev_q;
    logic [AW:0]   addr_q, addr_d;
    logic          sel_q, sel_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          rply_q, rply_d;
    logic          oe_q, oe_d;
    logic [15:0]   out_q, out_d;
    logic [15:0]   ram [DEPTH];

    logic          w_sync, w_din, w_dout, w_wtbt, w_sync_rise;
    logic [15:0]   w_ad;
    logic [AW-1:0] w_idx;
    logic          w_in_cycle, w_release, w_ram_we;

`ifdef MPI_VEC_EN
    logic [1:0]    iako_ff_q;
    logic          virq_q, virq_d;
    logic          w_iako;
`endif

    // Strobes are kept active-high internally; AD runs through an equal-depth
    // pipeline so the sampled address/data lines up with the synced strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff_q   <= '0;
            din_ff_q    <= '0;
            dout_ff_q   <= '0;
            wtbt_ff_q   <= '0;
            ad1_q       <= '0;
            ad2_q       <= '0;
            sync_prev_q <= 1'b0;
`ifdef MPI_VEC_EN
            iako_ff_q   <= '0;
`endif
        end else begin
            sync_ff_q   <= {sync_ff_q[0], ~bus.pin_sync_n};
            din_ff_q    <= {din_ff_q[0],  ~bus.pin_din_n};
            dout_ff_q   <= {dout_ff_q[0], ~bus.pin_dout_n};
            wtbt_ff_q   <= {wtbt_ff_q[0], ~bus.pin_wtbt_n};
            ad1_q       <= ~bus.pin_ad_in;
            ad2_q       <= ad1_q;
            sync_prev_q <= sync_ff_q[1];
`ifdef MPI_VEC_EN
            iako_ff_q   <= {iako_ff_q[0], ~bus.pin_iako_n};
`endif
        end
    end

    assign w_sync      = sync_ff_q[1];
    assign w_din       = din_ff_q[1];
    assign w_dout      = dout_ff_q[1];
    assign w_wtbt      = wtbt_ff_q[1];
    assign w_ad        = ad2_q;
    assign w_sync_rise = w_sync & ~sync_prev_q;
    assign w_idx       = addr_q[AW:1];

`ifdef MPI_VEC_EN
    assign w_iako     = iako_ff_q[1];
    assign w_in_cycle = (state_q != S_IDLE) && (state_q != S_IAK);
    assign w_release  = ((state_q == S_RD_RPLY) && !w_din)  ||
                        ((state_q == S_WR_RPLY) && !w_dout) ||
                        ((state_q == S_IAK)     && !w_din);
`else
    assign w_in_cycle = (state_q != S_IDLE);
    assign w_release  = ((state_q == S_RD_RPLY) && !w_din) ||
                        ((state_q == S_WR_RPLY) && !w_dout);
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rply_d  = rply_q;
        oe_d    = oe_q;
        out_d   = out_q;
`ifdef MPI_VEC_EN
        virq_d  = virq_q;
        if (bus.irq_req) begin
            virq_d = 1'b1;
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (w_sync_rise) begin
                    state_d = S_ADDR;
                    addr_d  = w_ad[AW:0];
                    sel_d   = (w_ad[15:AW+1] == BASE[15:AW+1]);
                end
`ifdef MPI_VEC_EN
                else if (w_din && !w_sync && w_iako) begin
                    state_d = S_IAK;
                    out_d   = ~VEC;
                    oe_d    = 1'b1;
                    rply_d  = 1'b1;
                    virq_d  = 1'b0;
                end
`endif
            end
            S_ADDR: begin
                // Read has priority when both strobes show up together.
                if (!sel_q) begin
                    state_d = S_END;
                end else if (w_din) begin
                    state_d = S_RD_WAIT;
                    cnt_d   = 4'd0;
                end else if (w_dout) begin
                    state_d = S_WR_WAIT;
                    cnt_d   = 4'd0;
                end
            end
            S_RD_WAIT: begin
                out_d = ~ram[w_idx];
                oe_d  = 1'b1;
                if (cnt_q == 4'(WAIT)) begin
                    state_d = S_RD_RPLY;
                    rply_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RD_RPLY: begin
                if (!w_din) begin
                    state_d = S_END;
                    rply_d  = 1'b0;
                    oe_d    = 1'b0;
                    out_d   = 16'hFFFF;
                end
            end
            S_WR_WAIT: begin
                if (cnt_q == 4'(WAIT)) begin
                    state_d = S_WR_RPLY;
                    rply_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WR_RPLY: begin
                if (!w_dout) begin
                    state_d = S_END;
                    rply_d  = 1'b0;
                end
            end
            S_END: begin
                if (!w_sync) begin
                    state_d = S_IDLE;
                end
            end
`ifdef MPI_VEC_EN
            S_IAK: begin
                if (!w_din) begin
                    state_d = S_IDLE;
                    rply_d  = 1'b0;
                    oe_d    = 1'b0;
                    out_d   = 16'hFFFF;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Losing SYNC mid-cycle aborts whatever was in progress.
        if (w_in_cycle && !w_sync) begin
            state_d = S_IDLE;
            rply_d  = 1'b0;
            oe_d    = 1'b0;
            out_d   = 16'hFFFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            sel_q   <= 1'b0;
            cnt_q   <= 4'd0;
            rply_q  <= 1'b0;
            oe_q    <= 1'b0;
            out_q   <= 16'hFFFF;
`ifdef MPI_VEC_EN
            virq_q  <= 1'b0;
`endif
        end else if (!bus.pin_init_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            sel_q   <= 1'b0;
            cnt_q   <= 4'd0;
            rply_q  <= 1'b0;
            oe_q    <= 1'b0;
            out_q   <= 16'hFFFF;
`ifdef MPI_VEC_EN
            virq_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rply_q  <= rply_d;
            oe_q    <= oe_d;
            out_q   <= out_d;
`ifdef MPI_VEC_EN
            virq_q  <= virq_d;
`endif
        end
    end

    // The single write happens on the ADDR->WR_WAIT edge, where w_ad is the data.
    assign w_ram_we = (state_q == S_ADDR) && (state_d == S_WR_WAIT) && bus.pin_init_n;

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            if (!w_wtbt || addr_q[0]) begin
                ram[w_idx][15:8] <= w_ad[15:8];
            end
            if (!w_wtbt || !addr_q[0]) begin
                ram[w_idx][7:0] <= w_ad[7:0];
            end
        end
    end

    // Strobe release drops RPLY/oe combinationally so the bus frees one clk sooner.
    assign bus.pin_rply_n = ~(rply_q & ~w_release);
    assign bus.pin_ad_oe  = oe_q & ~w_release;
    assign bus.pin_ad_out = (oe_q & ~w_release) ? out_q : 16'hFFFF;

`ifdef MPI_VEC_EN
    assign bus.pin_virq_n = ~virq_q;
`else
    logic w_unused;
    assign w_unused       = &{1'b0, bus.irq_req, bus.pin_iako_n};
    assign bus.pin_virq_n = 1'b1;
`endif

endmodule
`default_nettype wire
